// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and nibble validity helper for the N-digit BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: load, step up/down with roll-over, optional hold.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step,
  input  logic       up,
  input  logic       sat_hold,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= load_d;
    end else if (step && !sat_hold) begin
      if (up) q <= at_max ? BCD_MIN : q + 4'd1;
      else    q <= at_min ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with checked parallel load, wrap/saturate limits,
// cascade terminal count and a time-multiplexed digit scan port.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned SCAN_DIV = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_val,
  output logic [4*NDIGITS-1:0] count,
  output logic                 tc,
  output logic                 load_err,
  output logic [2:0]           digit_sel,
  output logic [3:0]           digit_out
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NDIGITS-1:0] at_max;
  logic [NDIGITS-1:0] at_min;
  logic [NDIGITS-1:0] nib_ok;
  logic [NDIGITS-1:0] lim;
  logic [NDIGITS:0]   lower_lim;
  bcd_digit_t         q_dig   [NDIGITS];
  bcd_digit_t         dig_pad [8];
  logic               load_ok;
  logic               sat_hold;
  logic [PW-1:0]      presc;
  logic               scan_wrap;
  logic [2:0]         sel_nxt;

  // lower_lim[k]: every digit below k sits at the limit for the current direction
  assign lower_lim[0] = 1'b1;

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    assign nib_ok[k]       = is_bcd(load_val[4*k +: 4]);
    assign lim[k]          = up ? at_max[k] : at_min[k];
    assign lower_lim[k+1]  = lower_lim[k] & lim[k];
    assign count[4*k +: 4] = q_dig[k];

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load_ok),
      .load_d   (load_val[4*k +: 4]),
      .step     (en & ~load & lower_lim[k]),
      .up       (up),
      .sat_hold (sat_hold),
      .q        (q_dig[k]),
      .at_max   (at_max[k]),
      .at_min   (at_min[k])
    );
  end

  // Scan mux source, padded to 8 entries so digit_sel indexes it directly
  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < NDIGITS) begin : g_used
      assign dig_pad[k] = q_dig[k];
    end else begin : g_unused
      assign dig_pad[k] = BCD_MIN;
    end
  end

  assign load_ok  = load & (&nib_ok);
  assign sat_hold = SATURATE & lower_lim[NDIGITS];
  assign tc       = en & ~load & lower_lim[NDIGITS];

  assign scan_wrap = (presc == PW'(SCAN_DIV - 1));
  assign sel_nxt   = (digit_sel == 3'(NDIGITS - 1)) ? 3'd0 : digit_sel + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err  <= 1'b0;
      presc     <= '0;
      digit_sel <= 3'd0;
      digit_out <= 4'd0;
    end else begin
      load_err <= load & ~(&nib_ok);
      if (scan_wrap) begin
        presc     <= '0;
        digit_sel <= sel_nxt;
        digit_out <= dig_pad[sel_nxt];
      end else begin
        presc     <= presc + PW'(1);
        digit_out <= dig_pad[digit_sel];
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: wrap/SCAN_DIV=4 and saturate/SCAN_DIV=1 instances checked
// against an integer-valued reference model.
module tb_bcd_counter_n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] cnt    [2];
  logic        tc_o   [2];
  logic        err_o  [2];
  logic [2:0]  sel_o  [2];
  logic [3:0]  dout_o [2];

  int n_cmp;
  int n_bad;

  // Reference model state: count held as a plain integer 0..9999
  int m_val   [2];
  int m_presc [2];
  int m_sel   [2];
  int m_dout  [2];
  bit m_err   [2];
  bit m_tc    [2];
  bit obs_tc  [2];

  bcd_counter_n #(.NDIGITS(4), .SCAN_DIV(4), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tc_o[0]), .load_err(err_o[0]),
    .digit_sel(sel_o[0]), .digit_out(dout_o[0])
  );

  bcd_counter_n #(.NDIGITS(4), .SCAN_DIV(1), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tc_o[1]), .load_err(err_o[1]),
    .digit_sel(sel_o[1]), .digit_out(dout_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit valid_of(input logic [15:0] lv);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) if (lv[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int val_of(input logic [15:0] lv);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      v = v + int'(lv[4*k +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic int dig_of(input int v, input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return (v / p) % 10;
  endfunction

  // Apply one cycle of inputs, capture tc before the edge, advance the model
  task automatic drive(input bit r, input bit e, input bit u, input bit l, input logic [15:0] lv);
    int old_v;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_val = lv;
    #1;
    for (int i = 0; i < 2; i++) begin
      obs_tc[i] = tc_o[i];
      m_tc[i]   = e && !l && (u ? (m_val[i] == 9999) : (m_val[i] == 0));
      old_v     = m_val[i];
      if (r) begin
        m_val[i] = 0; m_err[i] = 1'b0;
        m_presc[i] = 0; m_sel[i] = 0; m_dout[i] = 0;
      end else begin
        m_err[i] = l && !valid_of(lv);
        if (l) begin
          if (valid_of(lv)) m_val[i] = val_of(lv);
        end else if (e) begin
          if (u) m_val[i] = (old_v == 9999) ? (sat_of(i) ? 9999 : 0) : old_v + 1;
          else   m_val[i] = (old_v == 0)    ? (sat_of(i) ? 0 : 9999) : old_v - 1;
        end
        if (m_presc[i] == div_of(i) - 1) begin
          m_presc[i] = 0;
          m_sel[i]   = (m_sel[i] + 1) % 4;
        end else begin
          m_presc[i] = m_presc[i] + 1;
        end
        m_dout[i] = dig_of(old_v, m_sel[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 16'h0000);
    drive(1, 0, 1, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 4;
      if (cnt[i] !== 16'h0000) begin n_bad++; $display("FAIL reset_count dut%0d: got %h want 0000", i, cnt[i]); end
      if (err_o[i] !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d: got %b want 0", i, err_o[i]); end
      if (sel_o[i] !== 3'd0) begin n_bad++; $display("FAIL reset_sel dut%0d: got %0d want 0", i, sel_o[i]); end
      if (dout_o[i] !== 4'd0) begin n_bad++; $display("FAIL reset_dout dut%0d: got %0d want 0", i, dout_o[i]); end
    end
  endtask

  task automatic test_count_up();
    for (int n = 1; n <= 120; n++) begin
      drive(0, 1, 1, 0, 16'h0000);
      for (int i = 0; i < 2; i++) begin
        n_cmp += 2;
        if (cnt[i] !== bcd_of(m_val[i])) begin
          n_bad++; $display("FAIL count_up dut%0d step %0d: got %h want %h", i, n, cnt[i], bcd_of(m_val[i]));
        end
        if (obs_tc[i] !== m_tc[i]) begin
          n_bad++; $display("FAIL count_up_tc dut%0d step %0d: got %b want %b", i, n, obs_tc[i], m_tc[i]);
        end
      end
      if (n == 10 || n == 100) begin
        n_cmp++;
        if (cnt[0] !== ((n == 10) ? 16'h0010 : 16'h0100)) begin
          n_bad++; $display("FAIL count_carry step %0d: got %h", n, cnt[0]);
        end
      end
    end
  endtask

  task automatic test_limits();
    drive(0, 0, 1, 1, 16'h9999);
    drive(0, 1, 1, 0, 16'h0000);
    n_cmp += 4;
    if (obs_tc[0] !== 1'b1) begin n_bad++; $display("FAIL tc_up_wrap: got %b want 1", obs_tc[0]); end
    if (obs_tc[1] !== 1'b1) begin n_bad++; $display("FAIL tc_up_sat: got %b want 1", obs_tc[1]); end
    if (cnt[0] !== 16'h0000) begin n_bad++; $display("FAIL up_wrap: got %h want 0000", cnt[0]); end
    if (cnt[1] !== 16'h9999) begin n_bad++; $display("FAIL up_sat: got %h want 9999", cnt[1]); end

    drive(0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 16'h0000);
    n_cmp += 4;
    if (obs_tc[0] !== 1'b1) begin n_bad++; $display("FAIL tc_dn_wrap: got %b want 1", obs_tc[0]); end
    if (obs_tc[1] !== 1'b1) begin n_bad++; $display("FAIL tc_dn_sat: got %b want 1", obs_tc[1]); end
    if (cnt[0] !== 16'h9999) begin n_bad++; $display("FAIL dn_wrap: got %h want 9999", cnt[0]); end
    if (cnt[1] !== 16'h0000) begin n_bad++; $display("FAIL dn_sat: got %h want 0000", cnt[1]); end

    drive(0, 0, 0, 1, 16'h1000);
    drive(0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (cnt[i] !== 16'h0999) begin n_bad++; $display("FAIL borrow dut%0d: got %h want 0999", i, cnt[i]); end
      if (obs_tc[i] !== 1'b0) begin n_bad++; $display("FAIL borrow_tc dut%0d: got %b want 0", i, obs_tc[i]); end
    end
  endtask

  task automatic test_load();
    drive(0, 0, 1, 1, 16'h0100);
    drive(0, 1, 1, 1, 16'h12A4);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (cnt[i] !== 16'h0100) begin n_bad++; $display("FAIL bad_load_hold dut%0d: got %h want 0100", i, cnt[i]); end
      if (err_o[i] !== 1'b1) begin n_bad++; $display("FAIL bad_load_err dut%0d: got %b want 1", i, err_o[i]); end
    end
    drive(0, 0, 1, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (err_o[i] !== 1'b0) begin n_bad++; $display("FAIL err_pulse dut%0d: got %b want 0", i, err_o[i]); end
      if (cnt[i] !== 16'h0100) begin n_bad++; $display("FAIL idle_hold dut%0d: got %h want 0100", i, cnt[i]); end
    end
    drive(0, 1, 1, 1, 16'h0042);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (cnt[i] !== 16'h0042) begin n_bad++; $display("FAIL load_wins dut%0d: got %h want 0042", i, cnt[i]); end
      if (err_o[i] !== 1'b0) begin n_bad++; $display("FAIL good_load_err dut%0d: got %b want 0", i, err_o[i]); end
    end
  endtask

  task automatic test_scan();
    drive(0, 0, 1, 1, 16'h4321);
    for (int n = 0; n < 24; n++) begin
      drive(0, 0, 1, 0, 16'h0000);
      for (int i = 0; i < 2; i++) begin
        n_cmp += 2;
        if (sel_o[i] !== 3'(m_sel[i])) begin
          n_bad++; $display("FAIL scan_sel dut%0d cyc %0d: got %0d want %0d", i, n, sel_o[i], m_sel[i]);
        end
        if (dout_o[i] !== 4'(m_dout[i])) begin
          n_bad++; $display("FAIL scan_dout dut%0d cyc %0d: got %0d want %0d", i, n, dout_o[i], m_dout[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    drive(0, 0, 1, 1, 16'h0530);
    for (int n = 0; n < 7; n++) drive(0, 1, 1, 0, 16'h0000);
    n_cmp++;
    if (cnt[0] !== 16'h0537) begin n_bad++; $display("FAIL mid_setup: got %h want 0537", cnt[0]); end
    guard = 0;
    while (m_sel[0] != 2 && guard < 20) begin
      drive(0, 0, 1, 0, 16'h0000);
      guard++;
    end
    n_cmp++;
    if (sel_o[0] !== 3'd2) begin n_bad++; $display("FAIL mid_sel: got %0d want 2", sel_o[0]); end
    drive(1, 1, 1, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 3;
      if (cnt[i] !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_count dut%0d: got %h want 0000", i, cnt[i]); end
      if (sel_o[i] !== 3'd0) begin n_bad++; $display("FAIL mid_rst_sel dut%0d: got %0d want 0", i, sel_o[i]); end
      if (dout_o[i] !== 4'd0) begin n_bad++; $display("FAIL mid_rst_dout dut%0d: got %0d want 0", i, dout_o[i]); end
    end
    drive(0, 1, 1, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (cnt[i] !== 16'h0001) begin n_bad++; $display("FAIL mid_resume dut%0d: got %h want 0001", i, cnt[i]); end
    end
  endtask

  task automatic test_random();
    bit          r, e, u, l;
    logic [15:0] lv;
    int          pick;
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom % 50) == 0;
      l    = ($urandom % 6) == 0;
      e    = ($urandom % 4) != 0;
      u    = $urandom % 2;
      pick = $urandom % 8;
      if (pick == 0)      lv = 16'h9999;
      else if (pick == 1) lv = 16'h0000;
      else if (pick < 5)  lv = bcd_of($urandom_range(0, 9999));
      else                lv = 16'($urandom);
      drive(r, e, u, l, lv);
      for (int i = 0; i < 2; i++) begin
        n_cmp += 5;
        if (cnt[i] !== bcd_of(m_val[i])) begin
          n_bad++; $display("FAIL rnd_count dut%0d cyc %0d: got %h want %h", i, n, cnt[i], bcd_of(m_val[i]));
        end
        if (obs_tc[i] !== m_tc[i]) begin
          n_bad++; $display("FAIL rnd_tc dut%0d cyc %0d: got %b want %b", i, n, obs_tc[i], m_tc[i]);
        end
        if (err_o[i] !== m_err[i]) begin
          n_bad++; $display("FAIL rnd_err dut%0d cyc %0d: got %b want %b", i, n, err_o[i], m_err[i]);
        end
        if (sel_o[i] !== 3'(m_sel[i])) begin
          n_bad++; $display("FAIL rnd_sel dut%0d cyc %0d: got %0d want %0d", i, n, sel_o[i], m_sel[i]);
        end
        if (dout_o[i] !== 4'(m_dout[i])) begin
          n_bad++; $display("FAIL rnd_dout dut%0d cyc %0d: got %0d want %0d", i, n, dout_o[i], m_dout[i]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_presc[i] = 0; m_sel[i] = 0; m_dout[i] = 0;
      m_err[i] = 1'b0; m_tc[i] = 1'b0; obs_tc[i] = 1'b0;
    end
    test_reset();
    test_count_up();
    test_limits();
    test_load();
    test_scan();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
